i2s_tx_serializer: RTL and testbench

- Output stage downstream of the 16-bit state-variable filter.
- Takes one signed 16-bit stereo sample pair per audio frame through a valid/ready handshake and serializes it as Philips-format I2S: BCLK, LRCLK and SDATA, all generated from the system clock.
- Issues a one-clock frame strobe that upstream voice, envelope and filter logic use as the sample-rate tick.
- Has a one-entry holding buffer, so upstream has a full frame time to produce the next sample.

---
 rtl/i2s_tx_serializer.sv | 72 +++++++
 tb/tb_i2s_tx_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: valid/ready stereo sample pair to Philips I2S with frame strobe and underrun flag
module i2s_tx_serializer #(
  parameter int CLK_DIV = 4,
  parameter int SLOT_BITS = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        frame_start,
  output logic        underrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int KW = $clog2(2 * SLOT_BITS);
  localparam int PAD = SLOT_BITS - 16;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * SLOT_BITS - 1);
  localparam logic [KW-1:0] K_LR_ON = KW'(SLOT_BITS - 1);
  localparam logic [KW-1:0] K_LR_OFF = KW'(2 * SLOT_BITS - 2);
  logic [DW-1:0] div;
  logic [KW-1:0] k, k_nx;
  logic [15:0] hold_l, hold_r;
  logic [2*SLOT_BITS-1:0] sh, sh_nx;
  logic full, full_nx, accept, fall, load;
  always_comb begin
    accept = in_valid && in_ready;
    fall = div == DIV_MAX && i2s_bclk;
    k_nx = k == K_LAST ? '0 : k + 1'b1;
    load = fall && k_nx == '0;
    // on underrun the shift register keeps the previous pair, so it is simply resent
    sh_nx = load && full ? {SLOT_BITS'(hold_l) << PAD, SLOT_BITS'(hold_r) << PAD} : sh;
    full_nx = accept || (full && !load);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div <= '0;
      k <= K_LAST;
      i2s_bclk <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_data <= 1'b0;
      in_ready <= 1'b1;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      sh <= '0;
    end else begin
      div <= div == DIV_MAX ? '0 : div + 1'b1;
      if (div == DIV_MAX) i2s_bclk <= !i2s_bclk;
      if (fall) begin
        k <= k_nx;
        i2s_lrclk <= k_nx >= K_LR_ON && k_nx <= K_LR_OFF;
        i2s_data <= sh_nx[K_LAST - k_nx];
      end
      frame_start <= load;
      underrun <= load && !full;
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end
      full <= full_nx;
      in_ready <= !full_nx;
      sh <= sh_nx;
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: vector table plus scoreboard of accepted pairs against the deserialized I2S stream
module tb_i2s_tx_serializer;
  typedef struct {
    logic [15:0] l, r;
    bit offer, exp_ur;
    int dly;
  } vec_t;
  logic clk = 0, resetn = 0, in_valid = 0;
  logic [15:0] in_left = 0, in_right = 0;
  logic in_ready, bclk, lrclk, sdata, fs, ur;
  logic rst24n = 0, v24 = 0;
  logic [15:0] l24 = 0, r24 = 0;
  logic rdy24, bclk24, lr24, d24, fs24, ur24;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  i2s_tx_serializer dut (
    .clk(clk), .resetn(resetn), .in_left(in_left), .in_right(in_right), .in_valid(in_valid),
    .in_ready(in_ready), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_data(sdata),
    .frame_start(fs), .underrun(ur)
  );
  i2s_tx_serializer #(.CLK_DIV(4), .SLOT_BITS(24)) u24 (
    .clk(clk), .resetn(rst24n), .in_left(l24), .in_right(r24), .in_valid(v24),
    .in_ready(rdy24), .i2s_bclk(bclk24), .i2s_lrclk(lr24), .i2s_data(d24),
    .frame_start(fs24), .underrun(ur24)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // scoreboard: accepted pairs queue up, each frame start pops one or repeats the last
  logic p_rst = 1, p_acc = 0;
  logic [31:0] p_pair = 0;
  always @(posedge clk) begin
    p_rst <= !resetn;
    p_acc <= resetn && in_valid && in_ready;
    p_pair <= {in_left, in_right};
  end
  logic [31:0] q[$];
  logic [31:0] cur = 0, last = 0, rx = 0, lrx = 0;
  int nbits = 0;
  bit active = 0, prev_b = 0, exp_ur = 0;
  always @(negedge clk) begin
    if (p_rst) begin
      q.delete();
      last = 0;
      active = 0;
    end else begin
      if (fs === 1'b1) begin
        exp_ur = q.size() == 0;
        if (exp_ur) cur = last;
        else cur = q.pop_front();
        chk("sb_underrun", ur, exp_ur);
        last = cur;
        active = 1;
        nbits = 0;
      end
      if (p_acc) q.push_back(p_pair);
      if (active && bclk && !prev_b) begin
        rx = {rx[30:0], sdata};
        lrx = {lrx[30:0], lrclk};
        nbits++;
        if (nbits == 32) begin
          chk("sb_sdata", rx, cur);
          chk("sb_lrclk", lrx, 32'h0001fffe);
          active = 0;
        end
      end
    end
    prev_b = bclk;
  end
  task automatic do_reset();
    resetn = 0;
    in_valid = 0;
    @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_data", sdata, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_fs", fs, 0);
    chk("rst_ur", ur, 0);
    resetn = 1;
  endtask
  task automatic restart_check();
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk($sformatf("rs%0d_bclk", n), bclk, n >= 4 && n < 8);
      chk($sformatf("rs%0d_fs", n), fs, n == 8);
      chk($sformatf("rs%0d_ur", n), ur, n == 8);
      chk($sformatf("rs%0d_lrclk", n), lrclk, 0);
      chk($sformatf("rs%0d_data", n), sdata, 0);
    end
  endtask
  task automatic wait_fs(output logic rdy_before);
    int n = 0;
    rdy_before = in_ready;
    do begin
      rdy_before = in_ready;
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 600);
    chk("frame_start_seen", fs, 1);
  endtask
  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    while (in_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_left = l;
    in_right = r;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    in_left = 16'($urandom);
    in_right = 16'($urandom);
  endtask
  initial begin
    vec_t tbl[14];
    logic rb;
    int cnt, n, rises;
    bit prev;
    logic [47:0] rx48, lr48;
    for (int i = 0; i < 10; i++) tbl[i] = '{16'h1000 + 16'(i), 16'hf000 - 16'(i), 1'b1, 1'b0, 0};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 0};
    tbl[11] = '{16'h8000, 16'h7fff, 1'b1, 1'b0, 100};
    tbl[12] = '{16'hffff, 16'h0000, 1'b1, 1'b0, 0};
    tbl[13] = '{16'h0001, 16'hfffe, 1'b1, 1'b0, 0};
    do_reset();
    restart_check();
    do_reset();
    in_left = 16'h8001;
    in_right = 16'h7ffe;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    wait_fs(rb);
    chk("first_underrun", ur, 0);
    chk("first_ready_before", rb, 0);
    chk("first_ready_at_fs", in_ready, 1);
    foreach (tbl[i]) begin
      repeat (tbl[i].dly) @(negedge clk);
      if (tbl[i].offer) offer(tbl[i].l, tbl[i].r);
      wait_fs(rb);
      chk($sformatf("vec%0d_underrun", i), ur, tbl[i].exp_ur);
      chk($sformatf("vec%0d_ready_before", i), rb, tbl[i].exp_ur);
      chk($sformatf("vec%0d_ready_at_fs", i), in_ready, 1);
    end
    wait_fs(rb);
    offer(16'h5555, 16'haaaa);
    chk("mid_ready_full", in_ready, 0);
    prev = bclk;
    cnt = 0;
    n = 0;
    while (cnt < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (prev && !bclk) cnt++;
      prev = bclk;
    end
    chk("k10_reached", 64'(cnt), 10);
    do_reset();
    restart_check();
    wait_fs(rb);
    chk("post_rst_underrun", ur, 1);
    rst24n = 0;
    @(negedge clk);
    rst24n = 1;
    chk("s24_rst_ready", rdy24, 1);
    l24 = 16'h1234;
    r24 = 16'habcd;
    v24 = 1;
    @(negedge clk);
    v24 = 0;
    n = 0;
    while (fs24 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s24_fs", fs24, 1);
    chk("s24_underrun", ur24, 0);
    n = 0;
    rises = 0;
    prev = bclk24;
    rx48 = 0;
    lr48 = 0;
    do begin
      @(negedge clk);
      n++;
      if (bclk24 && !prev) begin
        rx48 = {rx48[46:0], d24};
        lr48 = {lr48[46:0], lr24};
        rises++;
      end
      prev = bclk24;
    end while (fs24 !== 1'b1 && n < 1000);
    chk("s24_frame_clks", 64'(n), 384);
    chk("s24_rises", 64'(rises), 48);
    chk("s24_sdata", rx48, 48'h123400abcd00);
    chk("s24_lrclk", lr48, 48'h000001fffffe);
    chk("s24_next_underrun", ur24, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
